// File: rtl/mdf_reservation_station_if.sv
// Dispatch, CDB and functional-unit signals of the mul/div/mod reservation station.
// The slave modport is the station's view; master is the surrounding core.
interface mdf_reservation_station_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 2
);
    logic              issueEN;
    logic [OP_W-1:0]   issueOp;
    logic [TAG_W-1:0]  issueQj;
    logic [TAG_W-1:0]  issueQk;
    logic [DATA_W-1:0] issueVj;
    logic [DATA_W-1:0] issueVk;
    logic              full;
    logic [TAG_W-1:0]  issueTag;
    logic              cdbEN;
    logic [TAG_W-1:0]  cdbTag;
    logic [DATA_W-1:0] cdbData;
    logic              fuBusy;
    logic              fuDone;
    logic              fuEN;
    logic [OP_W-1:0]   fuOp;
    logic [DATA_W-1:0] fuData1;
    logic [DATA_W-1:0] fuData2;
    logic [TAG_W-1:0]  fuTag;

    modport master (
        output issueEN, issueOp, issueQj, issueQk, issueVj, issueVk,
        input  full, issueTag,
        output cdbEN, cdbTag, cdbData,
        output fuBusy, fuDone,
        input  fuEN, fuOp, fuData1, fuData2, fuTag
    );

    modport slave (
        input  issueEN, issueOp, issueQj, issueQk, issueVj, issueVk,
        output full, issueTag,
        input  cdbEN, cdbTag, cdbData,
        input  fuBusy, fuDone,
        output fuEN, fuOp, fuData1, fuData2, fuTag
    );
endinterface

// File: rtl/mdf_reservation_station.sv
// Tomasulo reservation station for the non-pipelined multiply/divide/mod unit:
// holds operands or producer tags, snoops the CDB, launches one ready entry at a time.
module mdf_reservation_station #(
    parameter int ENTRIES  = 3,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 32,
    parameter int OP_W     = 2,
    parameter int BASE_TAG = 4
) (
    input logic                     clk,
    input logic                     nRST,
    mdf_reservation_station_if.slave bus
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC} ent_state_t;

    ent_state_t        state_q [ENTRIES];
    ent_state_t        state_d [ENTRIES];
    logic [OP_W-1:0]   op_q    [ENTRIES];
    logic [OP_W-1:0]   op_d    [ENTRIES];
    logic [TAG_W-1:0]  qj_q    [ENTRIES];
    logic [TAG_W-1:0]  qj_d    [ENTRIES];
    logic [TAG_W-1:0]  qk_q    [ENTRIES];
    logic [TAG_W-1:0]  qk_d    [ENTRIES];
    logic [DATA_W-1:0] vj_q    [ENTRIES];
    logic [DATA_W-1:0] vj_d    [ENTRIES];
    logic [DATA_W-1:0] vk_q    [ENTRIES];
    logic [DATA_W-1:0] vk_d    [ENTRIES];

    logic             full_q;
    logic             has_free, has_ready, exec_any, any_free_d;
    logic [IDX_W-1:0] free_idx, ready_idx;
    logic             issue_go, launch_go;
    logic             byp_j, byp_k;
    logic [TAG_W-1:0]  iss_qj, iss_qk;
    logic [DATA_W-1:0] iss_vj, iss_vk;

    function automatic logic [TAG_W-1:0] entry_tag(input int idx);
        return TAG_W'(BASE_TAG + idx);
    endfunction

    // Priority scan: descending loop leaves the lowest matching index.
    always_comb begin
        has_free  = 1'b0;
        has_ready = 1'b0;
        exec_any  = 1'b0;
        free_idx  = '0;
        ready_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (state_q[i] == ST_READY) begin
                has_ready = 1'b1;
                ready_idx = IDX_W'(i);
            end
            if (state_q[i] == ST_EXEC) exec_any = 1'b1;
        end
    end

    assign bus.issueTag = has_free ? entry_tag(int'(free_idx)) : '0;
    assign bus.full     = full_q;

    assign issue_go  = bus.issueEN && !full_q;
    assign launch_go = !exec_any && !bus.fuBusy && has_ready;

    // A broadcast in the dispatch cycle supplies the operand directly.
    assign byp_j  = bus.cdbEN && (bus.issueQj != '0) && (bus.cdbTag == bus.issueQj);
    assign byp_k  = bus.cdbEN && (bus.issueQk != '0) && (bus.cdbTag == bus.issueQk);
    assign iss_qj = byp_j ? '0 : bus.issueQj;
    assign iss_qk = byp_k ? '0 : bus.issueQk;
    assign iss_vj = byp_j ? bus.cdbData : bus.issueVj;
    assign iss_vk = byp_k ? bus.cdbData : bus.issueVk;

    always_comb begin
        logic cap_j, cap_k;
        cap_j      = 1'b0;
        cap_k      = 1'b0;
        any_free_d = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            state_d[i] = state_q[i];
            op_d[i]    = op_q[i];
            qj_d[i]    = qj_q[i];
            qk_d[i]    = qk_q[i];
            vj_d[i]    = vj_q[i];
            vk_d[i]    = vk_q[i];
            cap_j      = 1'b0;
            cap_k      = 1'b0;
            case (state_q[i])
                ST_FREE: begin
                    if (issue_go && (free_idx == IDX_W'(i))) begin
                        op_d[i]    = bus.issueOp;
                        qj_d[i]    = iss_qj;
                        qk_d[i]    = iss_qk;
                        vj_d[i]    = iss_vj;
                        vk_d[i]    = iss_vk;
                        state_d[i] = (iss_qj == '0 && iss_qk == '0) ? ST_READY : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cap_j = bus.cdbEN && (qj_q[i] != '0) && (qj_q[i] == bus.cdbTag);
                    cap_k = bus.cdbEN && (qk_q[i] != '0) && (qk_q[i] == bus.cdbTag);
                    if (cap_j) begin
                        qj_d[i] = '0;
                        vj_d[i] = bus.cdbData;
                    end
                    if (cap_k) begin
                        qk_d[i] = '0;
                        vk_d[i] = bus.cdbData;
                    end
                    if (qj_d[i] == '0 && qk_d[i] == '0) state_d[i] = ST_READY;
                end
                ST_READY: begin
                    if (launch_go && (ready_idx == IDX_W'(i))) state_d[i] = ST_EXEC;
                end
                ST_EXEC: begin
                    if (bus.fuDone) state_d[i] = ST_FREE;
                end
                default: state_d[i] = ST_FREE;
            endcase
            if (state_d[i] == ST_FREE) any_free_d = 1'b1;
        end
    end

    // Control state and launch registers.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) state_q[i] <= ST_FREE;
            full_q      <= 1'b0;
            bus.fuEN    <= 1'b0;
            bus.fuOp    <= '0;
            bus.fuData1 <= '0;
            bus.fuData2 <= '0;
            bus.fuTag   <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) state_q[i] <= state_d[i];
            full_q   <= !any_free_d;
            bus.fuEN <= launch_go;
            if (launch_go) begin
                bus.fuOp    <= op_q[ready_idx];
                bus.fuData1 <= vj_q[ready_idx];
                bus.fuData2 <= vk_q[ready_idx];
                bus.fuTag   <= entry_tag(int'(ready_idx));
            end else if (bus.fuDone && exec_any) begin
                bus.fuTag <= '0;
            end
        end
    end

    // Operand storage is only meaningful while its entry is allocated.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            op_q[i] <= op_d[i];
            qj_q[i] <= qj_d[i];
            qk_q[i] <= qk_d[i];
            vj_q[i] <= vj_d[i];
            vk_q[i] <= vk_d[i];
        end
    end
endmodule

// File: tb/tb_mdf_reservation_station.sv
// Bench for mdf_reservation_station: vector table of single-instruction round trips
// plus hand-written sequences for fill, busy hold and reset mid-execution.
module tb_mdf_reservation_station;
    logic clk = 1'b0;
    logic nRST;
    always #5 clk = ~clk;

    mdf_reservation_station_if #(.TAG_W(4), .DATA_W(32), .OP_W(2)) bus ();

    mdf_reservation_station #(
        .ENTRIES(3), .TAG_W(4), .DATA_W(32), .OP_W(2), .BASE_TAG(4)
    ) dut (
        .clk (clk),
        .nRST(nRST),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  qj, qk;
        logic [31:0] vj, vk;
        bit          byp_en;
        logic [3:0]  byp_tag;
        logic [31:0] byp_data;
        bit          late_en;
        logic [3:0]  late_tag;
        logic [31:0] late_data;
        logic [31:0] exp1, exp2;
    } vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] d1, d2;
        logic [3:0]  tag;
    } launch_t;

    vec_t    vecs [7];
    launch_t sb[$];
    int      checks = 0;
    int      errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.issueEN = 1'b0; bus.issueOp = '0; bus.issueQj = '0; bus.issueQk = '0;
        bus.issueVj = '0;   bus.issueVk = '0;
        bus.cdbEN = 1'b0;   bus.cdbTag = '0;  bus.cdbData = '0;
        bus.fuDone = 1'b0;
    endtask

    task automatic drive_issue(input logic [1:0] op, input logic [3:0] qj, input logic [3:0] qk,
                               input logic [31:0] vj, input logic [31:0] vk);
        bus.issueEN = 1'b1; bus.issueOp = op; bus.issueQj = qj; bus.issueQk = qk;
        bus.issueVj = vj;   bus.issueVk = vk;
    endtask

    task automatic drive_cdb(input logic [3:0] tag, input logic [31:0] data);
        bus.cdbEN = 1'b1; bus.cdbTag = tag; bus.cdbData = data;
    endtask

    // Waits up to budget edges for a launch, then compares it with the scoreboard head.
    task automatic check_launch(input string name, input int budget);
        int n = 0;
        launch_t e;
        do begin
            @(negedge clk);
            n++;
        end while (bus.fuEN !== 1'b1 && n < budget);
        if (bus.fuEN !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s: fuEN got %b, expected 1 within %0d cycles", name, bus.fuEN, budget);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: launch tag %0h seen, expected none", name, bus.fuTag);
        end else begin
            e = sb.pop_front();
            chk(name, {bus.fuOp, bus.fuData1, bus.fuData2, bus.fuTag}, {e.op, e.d1, e.d2, e.tag});
        end
    endtask

    task automatic pulse_done();
        bus.fuDone = 1'b1;
        @(negedge clk);
        bus.fuDone = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, expected completion earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        vecs[0] = '{2'd0, 4'd0,  4'd0,  32'd5,        32'd10, 1'b0, 4'd0,  32'd0,  1'b0, 4'd0,  32'd0,        32'd5,        32'd10};
        vecs[1] = '{2'd1, 4'd9,  4'd0,  32'd100,      32'd3,  1'b0, 4'd0,  32'd0,  1'b1, 4'd9,  32'd7,        32'd7,        32'd3};
        vecs[2] = '{2'd2, 4'd8,  4'd8,  32'd1,        32'd1,  1'b1, 4'd8,  32'd2,  1'b0, 4'd0,  32'd0,        32'd2,        32'd2};
        vecs[3] = '{2'd3, 4'd0,  4'd12, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd0,  32'd0,  1'b1, 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[4] = '{2'd1, 4'd11, 4'd13, 32'd0,        32'd0,  1'b1, 4'd11, 32'd6,  1'b1, 4'd13, 32'd9,        32'd6,        32'd9};
        vecs[5] = '{2'd2, 4'd10, 4'd10, 32'd0,        32'd0,  1'b0, 4'd0,  32'd0,  1'b1, 4'd10, 32'd44,       32'd44,       32'd44};
        vecs[6] = '{2'd0, 4'd0,  4'd0,  32'd21,       32'd22, 1'b1, 4'd9,  32'd99, 1'b0, 4'd0,  32'd0,        32'd21,       32'd22};

        idle_inputs();
        bus.fuBusy = 1'b0;
        nRST = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_full", bus.full, 0);
        chk("rst_fuEN", bus.fuEN, 0);
        chk("rst_fuTag", bus.fuTag, 0);
        chk("rst_fuOp", bus.fuOp, 0);
        chk("rst_fuData", {bus.fuData1, bus.fuData2}, 0);
        chk("rst_issueTag", bus.issueTag, 4);
        nRST = 1'b1;
        @(negedge clk);

        // Single-instruction round trips through entry 0.
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("v%0d_issueTag", i), bus.issueTag, 4);
            drive_issue(vecs[i].op, vecs[i].qj, vecs[i].qk, vecs[i].vj, vecs[i].vk);
            if (vecs[i].byp_en) drive_cdb(vecs[i].byp_tag, vecs[i].byp_data);
            sb.push_back('{vecs[i].op, vecs[i].exp1, vecs[i].exp2, 4'd4});
            @(negedge clk);
            idle_inputs();
            chk($sformatf("v%0d_early", i), bus.fuEN, 0);
            if (vecs[i].late_en) begin
                drive_cdb(vecs[i].late_tag, vecs[i].late_data);
                @(negedge clk);
                idle_inputs();
                chk($sformatf("v%0d_wait", i), bus.fuEN, 0);
            end
            check_launch($sformatf("v%0d_launch", i), 1);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), {bus.fuEN, bus.fuTag}, {1'b0, 4'd4});
            pulse_done();
            chk($sformatf("v%0d_done", i), {bus.full, bus.fuTag}, {1'b0, 4'd0});
        end

        // Fill all entries waiting on tag 9, then release them with one broadcast.
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fill%0d_issueTag", i), bus.issueTag, 4 + i);
            drive_issue(2'(i), 4'd9, 4'd0, 32'd0, 32'(10 + i));
            @(negedge clk);
            idle_inputs();
        end
        chk("fill_full", {bus.full, bus.issueTag}, {1'b1, 4'd0});
        drive_issue(2'd3, 4'd0, 4'd0, 32'd1, 32'd1);
        @(negedge clk);
        idle_inputs();
        chk("fill_ignored", {bus.full, bus.fuEN}, {1'b1, 1'b0});
        drive_cdb(4'd9, 32'd7);
        for (int i = 0; i < 3; i++) sb.push_back('{2'(i), 32'd7, 32'(10 + i), 4'(4 + i)});
        @(negedge clk);
        idle_inputs();
        check_launch("fill_launch0", 1);
        for (int k = 0; k < 3; k++) begin
            seen = 1'b0;
            repeat (3) begin
                @(negedge clk);
                seen |= bus.fuEN;
            end
            chk($sformatf("fill%0d_hold", k), {seen, bus.fuTag}, {1'b0, 4'(4 + k)});
            pulse_done();
            chk($sformatf("fill%0d_done", k), {bus.full, bus.fuTag}, {1'b0, 4'd0});
            if (k < 2) check_launch($sformatf("fill_launch%0d", k + 1), 1);
        end
        chk("fill_empty", bus.issueTag, 4);

        // Busy unit holds back a ready entry.
        bus.fuBusy = 1'b1;
        drive_issue(2'd2, 4'd0, 4'd0, 32'd100, 32'd7);
        sb.push_back('{2'd2, 32'd100, 32'd7, 4'd4});
        @(negedge clk);
        idle_inputs();
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= bus.fuEN;
        end
        chk("busy_hold", seen, 0);
        bus.fuBusy = 1'b0;
        check_launch("busy_release", 1);
        @(negedge clk);
        pulse_done();
        chk("busy_done", bus.fuTag, 0);

        // Reset while an entry executes.
        drive_issue(2'd3, 4'd0, 4'd0, 32'h1234, 32'h5678);
        sb.push_back('{2'd3, 32'h1234, 32'h5678, 4'd4});
        @(negedge clk);
        idle_inputs();
        check_launch("rst_exec_launch", 1);
        #2 nRST = 1'b0;
        #1;
        chk("rst_mid_outputs", {bus.fuEN, bus.fuTag, bus.fuOp, bus.fuData1, bus.fuData2}, 0);
        chk("rst_mid_full", bus.full, 0);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        pulse_done();
        chk("rst_late_done", {bus.full, bus.fuTag, bus.fuEN, bus.issueTag}, {1'b0, 4'd0, 1'b0, 4'd4});
        drive_issue(2'd1, 4'd0, 4'd0, 32'd3, 32'd4);
        sb.push_back('{2'd1, 32'd3, 32'd4, 4'd4});
        @(negedge clk);
        idle_inputs();
        check_launch("rst_after_launch", 1);
        @(negedge clk);
        pulse_done();
        chk("rst_after_done", bus.fuTag, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdf_reservation_station.md
Name: mdf_reservation_station

Overview:
- Reservation station feeding the multiply/divide/mod functional unit in the Tomasulo core.
- Accepts dispatched mul/div instructions and holds operands or producer tags.
- Snoops the CDB for missing operands and launches one ready entry at a time into the non-pipelined MDF unit with a one-cycle enable pulse.
- Frees the executing entry when the unit's result has been accepted on the CDB.

Parameters:
ENTRIES, 3, number of station entries (1..7)
TAG_W, 4, tag width; tag 0 is reserved and means "operand value valid"
DATA_W, 32, operand width
OP_W, 2, operation code width, passed through to the unit
BASE_TAG, 4, tag of entry 0; entry i owns tag BASE_TAG+i (nonzero, fits TAG_W)

Ports:
clk  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
issueEN  in  1  dispatch request, sampled at rising edge
issueOp  in  OP_W  operation of dispatched instruction
issueQj  in  TAG_W  producer tag of operand 1 (0 = issueVj valid)
issueQk  in  TAG_W  producer tag of operand 2 (0 = issueVk valid)
issueVj  in  DATA_W  operand 1 value
issueVk  in  DATA_W  operand 2 value
full  out  1  registered; no free entry
issueTag  out  TAG_W  combinational; tag of the lowest-index FREE entry (0 when full)
cdbEN  in  1  CDB broadcast valid
cdbTag  in  TAG_W  CDB producer tag
cdbData  in  DATA_W  CDB value
fuBusy  in  1  functional unit not idle
fuDone  in  1  one-cycle pulse: unit result accepted on CDB
fuEN  out  1  registered one-cycle launch pulse
fuOp  out  OP_W  operation of launched entry
fuData1  out  DATA_W  operand 1 of launched entry
fuData2  out  DATA_W  operand 2 of launched entry
fuTag  out  TAG_W  tag of the executing entry (0 when none)

Behaviour:
- Reset (async, nRST=0): all entries FREE; full=0; fuEN=0; fuOp/fuData1/fuData2/fuTag=0. Reset mid-execution abandons the in-flight entry; a later fuDone is ignored.
- Entry states:
  - FREE->WAIT on issue when any Q is nonzero after bypass.
  - FREE->READY on issue when both Q are 0 after bypass.
  - WAIT->READY when the last Q is cleared by the CDB.
  - READY->EXEC on launch.
  - EXEC->FREE on fuDone.
- Issue: when issueEN=1 and full=0, the lowest-index FREE entry is written. When issueEN=1 and full=1, the request is ignored with no state change.
- CDB capture: each cycle with cdbEN=1, every WAIT entry whose Qj (or Qk) equals cdbTag latches cdbData into Vj (or Vk) and clears that Q. A single broadcast may clear both Qj and Qk.
- Issue bypass: if cdbEN=1 and cdbTag equals nonzero issueQj or issueQk in the issue cycle, cdbData is captured instead of issueVj/issueVk and the Q is stored as 0.
- Launch: at an edge where no entry is EXEC (registered), fuBusy=0, and some entry is READY, the lowest-index READY entry goes to EXEC.
  - fuEN=1 for exactly the following cycle.
  - fuOp, fuData1, fuData2 and fuTag are loaded at that edge and held stable until fuDone.
  - At most one entry is ever EXEC.
- Latency:
  - Issue with ready operands at edge N gives fuEN=1 after edge N+1.
  - An entry freed by fuDone at edge M: fuTag=0 after M, a new launch at earliest edge M+1, and the entry is reallocatable from edge M+1 (full falls after edge M).
- fuDone with no EXEC entry is ignored.
- full is recomputed every edge from the post-update entry states.

Test Plan:
- Reset, issue op=0 Qj=Qk=0 Vj=5 Vk=10 with fuBusy=0 -> issueTag=4 at issue; fuEN pulses one cycle after the following edge with fuData1=5, fuData2=10, fuTag=4; fuDone -> entry FREE, fuTag=0.
- Issue Qj=9 Vk=3; two cycles later cdbEN=1 cdbTag=9 cdbData=7 -> entry READY; launch with fuData1=7, fuData2=3.
- Fill 3 entries all waiting on tag 9 -> full=1; 4th issueEN ignored; cdbTag=9 broadcast readies all three; launches occur in tag order 4,5,6, each only after the previous fuDone.
- Issue Qj=Qk=8 in the same cycle as cdbEN=1 cdbTag=8 cdbData=2 -> entry stored READY with Vj=Vk=2.
- Hold fuBusy=1 with an entry READY -> fuEN stays 0; release fuBusy -> launch on the next edge.
- Assert nRST=0 while an entry is EXEC -> all outputs 0 immediately; a later fuDone pulse has no effect; full=0.
